mips_multicycle_control: RTL and testbench

- Multicycle MIPS control unit sitting directly upstream of the 32-bit ALU.
- Decodes the latched instruction's Op/Funct fields and steps a Moore FSM through fetch/decode/execute/memory/writeback.
- Drives the ALU's 4-bit AluOp and the operand-select muxes, and consumes the ALU Zero flag for beq.
- Waits on a memory-ready handshake; keeps a sticky illegal-instruction flag and a retired-instruction counter.

---
 rtl/mips_multicycle_control.sv | 202 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM stepping fetch/decode/execute/memory/writeback,
// driving ALU op and operand muxes, with a sticky illegal flag and a retired-instruction counter.
module mips_multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             AluSrcA,
   output logic [1:0]       AluSrcB,
   output logic [3:0]       AluOp,
   output logic [1:0]       PCSrc,
   output logic             PCEn,
   output logic             instr_done,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1010;

   state_t           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   function automatic logic funct_legal(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101,
         6'b100110, 6'b100111, 6'b101010: funct_legal = 1'b1;
         default:                         funct_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] funct_aluop(input logic [5:0] f);
      case (f)
         6'b100010: funct_aluop = ALU_SUB;
         6'b100100: funct_aluop = ALU_AND;
         6'b100101: funct_aluop = ALU_OR;
         6'b100110: funct_aluop = ALU_XOR;
         6'b100111: funct_aluop = ALU_NOR;
         6'b101010: funct_aluop = ALU_SLT;
         default:   funct_aluop = ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      AluSrcA    = 1'b0;
      AluSrcB    = 2'b00;
      AluOp      = ALU_ADD;
      PCSrc      = 2'b00;
      PCEn       = 1'b0;
      instr_done = 1'b0;

      case (state_q)
         S_FETCH: begin
            // PC+4 is computed every fetch cycle but only committed with the instruction.
            MemRead = 1'b1;
            AluSrcB = 2'b01;
            IRWrite = mem_ready;
            PCEn    = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            AluSrcB = 2'b11;
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               OP_RTYPE: begin
                  if (funct_legal(Funct)) begin
                     state_d = S_EXECUTE;
                  end else begin
                     state_d   = S_FETCH;
                     illegal_d = 1'b1;
                  end
               end
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
            state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTE: begin
            AluSrcA = 1'b1;
            AluOp   = funct_aluop(Funct);
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            // Target was parked in ALUOut during DECODE; the ALU now compares rs/rt.
            AluSrcA    = 1'b1;
            AluOp      = ALU_SUB;
            PCSrc      = 2'b01;
            PCEn       = Zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            PCSrc      = 2'b10;
            PCEn       = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      retired_d = retired_q;
      if (instr_done) retired_d = retired_q + CNT_W'(1);
   end

   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle output vectors checked against
// hand-derived constants, plus flag and counter checks (counter built 4 bits wide).
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op, Funct;
   logic       Zero, mem_ready;
   logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA;
   logic [1:0] AluSrcB, PCSrc;
   logic [3:0] AluOp;
   logic       PCEn, instr_done, illegal;
   logic [3:0] retired;

   int checks = 0;
   int errors = 0;
   int irw_cnt, rw_cnt;

   always #5 clk = ~clk;

   mips_multicycle_control #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
      .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSrc(PCSrc), .PCEn(PCEn),
      .instr_done(instr_done), .illegal(illegal), .retired(retired)
   );

   // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,AluSrcA}_AluSrcB_AluOp_PCSrc_{PCEn,instr_done}
   localparam logic [17:0] E_FETCH0  = 18'b01000000_01_0000_00_00;
   localparam logic [17:0] E_FETCH1  = 18'b01010000_01_0000_00_10;
   localparam logic [17:0] E_DECODE  = 18'b00000000_11_0000_00_00;
   localparam logic [17:0] E_MEMADR  = 18'b00000001_10_0000_00_00;
   localparam logic [17:0] E_MEMRD   = 18'b11000000_00_0000_00_00;
   localparam logic [17:0] E_MEMWB   = 18'b00000110_00_0000_00_01;
   localparam logic [17:0] E_MEMWR0  = 18'b10100000_00_0000_00_00;
   localparam logic [17:0] E_MEMWR1  = 18'b10100000_00_0000_00_01;
   localparam logic [17:0] E_EX_SLT  = 18'b00000001_00_1010_00_00;
   localparam logic [17:0] E_EX_ADD  = 18'b00000001_00_0000_00_00;
   localparam logic [17:0] E_ALUWB   = 18'b00001010_00_0000_00_01;
   localparam logic [17:0] E_BR_Z1   = 18'b00000001_00_0010_01_11;
   localparam logic [17:0] E_BR_Z0   = 18'b00000001_00_0010_01_01;
   localparam logic [17:0] E_ADDIEX  = 18'b00000001_10_0000_00_00;
   localparam logic [17:0] E_ADDIWB  = 18'b00000010_00_0000_00_01;
   localparam logic [17:0] E_JUMP    = 18'b00000000_00_0000_10_11;

   logic        lw_mr  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [17:0] lw_exp [10] = '{E_FETCH0, E_FETCH0, E_FETCH0, E_FETCH1, E_DECODE,
                                E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};

   function automatic logic [17:0] outv();
      return {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA,
              AluSrcB, AluOp, PCSrc, PCEn, instr_done};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [17:0] exp);
      chk(tag, {14'd0, outv()}, {14'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // check the current state's outputs, then advance one clock
   task automatic cyc(input string tag, input logic [17:0] exp);
      #1;
      chkv(tag, exp);
      tick();
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #2 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0; mem_ready = 1'b0;
      #12;
      chkv("reset_outputs", E_FETCH0);
      chk("reset_retired", 32'(retired), 32'd0);
      chk("reset_illegal", 32'(illegal), 32'd0);
      reset = 1'b0;

      // R-type SLT
      mem_ready = 1'b1; Op = 6'b000000; Funct = 6'b101010;
      cyc("slt_fetch", E_FETCH1);
      cyc("slt_decode", E_DECODE);
      cyc("slt_execute", E_EX_SLT);
      chk("slt_retired_before", 32'(retired), 32'd0);
      cyc("slt_aluwb", E_ALUWB);
      chk("slt_retired_after", 32'(retired), 32'd1);

      // lw with 3 FETCH stalls and 2 MEMRD stalls: 10 cycles
      Op = 6'b100011; irw_cnt = 0; rw_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         mem_ready = lw_mr[i];
         #1;
         chkv($sformatf("lw_cycle%0d", i), lw_exp[i]);
         irw_cnt += int'(IRWrite);
         rw_cnt  += int'(RegWrite);
         tick();
      end
      chk("lw_irwrite_count", irw_cnt, 1);
      chk("lw_regwrite_count", rw_cnt, 1);
      chk("lw_retired", 32'(retired), 32'd2);
      mem_ready = 1'b0;
      #1 chkv("lw_back_fetch", E_FETCH0);

      // sw interrupted by reset while MemWrite is asserted
      mem_ready = 1'b1; Op = 6'b101011;
      cyc("sw_fetch", E_FETCH1);
      cyc("sw_decode", E_DECODE);
      cyc("sw_memadr", E_MEMADR);
      mem_ready = 1'b0;
      #1 chkv("sw_memwr_wait", E_MEMWR0);
      #1 reset = 1'b1;
      #1;
      chk("rst_memwrite", 32'(MemWrite), 32'd0);
      chkv("rst_outputs", E_FETCH0);
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      #1 reset = 1'b0;

      // full sw with one stall in MEMWR
      mem_ready = 1'b1;
      cyc("sw2_fetch", E_FETCH1);
      cyc("sw2_decode", E_DECODE);
      cyc("sw2_memadr", E_MEMADR);
      mem_ready = 1'b0;
      cyc("sw2_memwr_wait", E_MEMWR0);
      mem_ready = 1'b1;
      cyc("sw2_memwr_done", E_MEMWR1);
      chk("sw2_retired", 32'(retired), 32'd1);

      // beq taken then not taken
      Op = 6'b000100; Zero = 1'b1;
      cyc("beq1_fetch", E_FETCH1);
      cyc("beq1_decode", E_DECODE);
      cyc("beq1_branch", E_BR_Z1);
      Zero = 1'b0;
      cyc("beq0_fetch", E_FETCH1);
      cyc("beq0_decode", E_DECODE);
      cyc("beq0_branch", E_BR_Z0);
      chk("beq_retired", 32'(retired), 32'd3);

      // addi
      Op = 6'b001000;
      cyc("addi_fetch", E_FETCH1);
      cyc("addi_decode", E_DECODE);
      cyc("addi_ex", E_ADDIEX);
      cyc("addi_wb", E_ADDIWB);
      chk("addi_retired", 32'(retired), 32'd4);

      // illegal opcode, then a jump still executes
      Op = 6'b111111;
      cyc("ill_fetch", E_FETCH1);
      chk("ill_before", 32'(illegal), 32'd0);
      cyc("ill_decode", E_DECODE);
      chk("ill_set", 32'(illegal), 32'd1);
      chk("ill_retired", 32'(retired), 32'd4);
      Op = 6'b000010;
      cyc("j_fetch", E_FETCH1);
      cyc("j_decode", E_DECODE);
      cyc("j_jump", E_JUMP);
      chk("j_illegal_sticky", 32'(illegal), 32'd1);
      chk("j_retired", 32'(retired), 32'd5);

      // illegal R-type funct
      do_reset();
      chk("rf_reset_illegal", 32'(illegal), 32'd0);
      Op = 6'b000000; Funct = 6'b000000;
      cyc("rf_fetch", E_FETCH1);
      cyc("rf_decode", E_DECODE);
      chk("rf_illegal", 32'(illegal), 32'd1);
      chk("rf_retired", 32'(retired), 32'd0);
      #1 chkv("rf_back_fetch", E_FETCH1);

      // 17 R-type adds on a 4-bit counter: wraps 15 -> 0, ends at 1
      do_reset();
      Funct = 6'b100000;
      for (int n = 1; n <= 17; n++) begin
         cyc("add_fetch", E_FETCH1);
         cyc("add_decode", E_DECODE);
         cyc("add_execute", E_EX_ADD);
         cyc("add_aluwb", E_ALUWB);
         if (n == 15) chk("wrap_at15", 32'(retired), 32'd15);
         if (n == 16) chk("wrap_at16", 32'(retired), 32'd0);
      end
      chk("wrap_final", 32'(retired), 32'd1);
      chk("wrap_illegal", 32'(illegal), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
